// File: rtl/pipe_memory_access_pkg.sv
// Shared encodings for the memory-access stage; the store stage's load
// extraction uses the same size and mask constants.
package pipe_memory_access_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;
  localparam logic [3:0] MASK_NONE = 4'b0000;

  function automatic logic [3:0] base_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: base_mask = MASK_BYTE;
      SIZE_HALF: base_mask = MASK_HALF;
      SIZE_WORD: base_mask = MASK_WORD;
      default:   base_mask = MASK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/memory_lane_align.sv
// Combinational lane decode: byte-lane mask, misaligned/invalid flags and
// lane-replicated store data from access size and address offset.
module memory_lane_align
  import pipe_memory_access_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  output logic [3:0]  o_lane_mask,
  output logic        o_misaligned,
  output logic        o_invalid,
  output logic [31:0] o_store_data
);

  logic [3:0] w_base;
  logic [7:0] w_shifted;

  assign w_base    = base_mask(i_size);
  // Lanes pushed past lane 3 mean the access straddles the word boundary.
  assign w_shifted = {4'b0000, w_base} << i_addr_lo;

  assign o_lane_mask  = w_shifted[3:0];
  assign o_misaligned = |w_shifted[7:4];
  assign o_invalid    = (w_base == MASK_NONE);

  always_comb begin
    o_store_data = i_store_data;
    case (i_size)
      SIZE_BYTE: o_store_data = {4{i_store_data[7:0]}};
      SIZE_HALF: o_store_data = {2{i_store_data[15:0]}};
      default:   o_store_data = i_store_data;
    endcase
  end

endmodule

// File: rtl/pipe_memory_access.sv
// Memory-access stage: launches one bus transaction per load/store, stalls
// the pipe until ack, captures read data and reports misalign/timeout faults.
module pipe_memory_access
  import pipe_memory_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMER_WIDTH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stepPipe,
  input  logic        pipeStall,
  input  logic        isLoad,
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic        memoryRequest,
  output logic        memoryWriteEnable,
  output logic [31:0] memoryAddress,
  output logic [3:0]  memoryByteSelect,
  output logic [31:0] memoryDataWrite,
  input  logic        memoryAck,
  input  logic [31:0] memoryDataIn,
  output logic [31:0] memoryDataRead,
  output logic        memoryStall,
  output logic        addressMisaligned,
  output logic        busError
);

  state_t r_state;
  state_t w_state_next;

  logic [TIMER_WIDTH-1:0] r_watchdog;
  logic [31:0] r_addr;
  logic [3:0]  r_lanes;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [31:0] r_rdata;
  logic        r_misaligned;
  logic        r_bus_error;

  logic [3:0]  w_lane_mask;
  logic        w_misaligned;
  logic        w_invalid;
  logic [31:0] w_store_data;
  logic        w_launch;
  logic        w_launch_ok;
  logic        w_timeout;
  logic        w_unused_funct3;

  // Sign/unsigned selection is the store stage's concern.
  assign w_unused_funct3 = funct3[2];

  memory_lane_align u_align (
    .i_size       (funct3[1:0]),
    .i_addr_lo    (address[1:0]),
    .i_store_data (storeData),
    .o_lane_mask  (w_lane_mask),
    .o_misaligned (w_misaligned),
    .o_invalid    (w_invalid),
    .o_store_data (w_store_data)
  );

  assign w_launch    = (r_state == ST_IDLE) & stepPipe & ~pipeStall & (isLoad | isStore);
  assign w_launch_ok = w_launch & ~w_misaligned & ~w_invalid;
  assign w_timeout   = (r_watchdog == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_launch_ok) w_state_next = ST_ACCESS;
      ST_ACCESS: if (memoryAck | w_timeout) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_watchdog   <= '0;
      r_addr       <= '0;
      r_lanes      <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_rdata      <= '0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_misaligned <= w_launch & w_misaligned;
      // Ack takes priority over a coincident timeout.
      r_bus_error  <= (r_state == ST_ACCESS) & w_timeout & ~memoryAck;
      if ((r_state == ST_ACCESS) & ~memoryAck & ~w_timeout) r_watchdog <= r_watchdog + 1'b1;
      else                                                    r_watchdog <= '0;
      if (w_launch_ok) begin
        r_addr  <= {address[31:2], 2'b00};
        r_lanes <= w_lane_mask;
        r_wdata <= w_store_data;
        r_we    <= isStore;
      end
      if ((r_state == ST_ACCESS) & memoryAck & ~r_we) r_rdata <= memoryDataIn;
    end
  end

  // Request is gated by rst so it falls the instant reset asserts.
  always_comb begin
    memoryRequest     = (r_state == ST_ACCESS) & ~rst;
    memoryStall       = (r_state == ST_ACCESS) & ~rst;
    memoryWriteEnable = r_we;
    memoryAddress     = r_addr;
    memoryByteSelect  = r_lanes;
    memoryDataWrite   = r_wdata;
    memoryDataRead    = r_rdata;
    addressMisaligned = r_misaligned;
    busError          = r_bus_error;
  end

endmodule

// File: tb/tb_pipe_memory_access.sv
// Directed bench for pipe_memory_access with a 4-cycle watchdog.
module tb_pipe_memory_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stepPipe = 1'b0, pipeStall = 1'b0, isLoad = 1'b0, isStore = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] address = '0, storeData = '0;
  logic        memoryRequest, memoryWriteEnable, memoryStall, addressMisaligned, busError;
  logic [31:0] memoryAddress, memoryDataWrite, memoryDataRead;
  logic [3:0]  memoryByteSelect;
  logic        memoryAck = 1'b0;
  logic [31:0] memoryDataIn = '0;

  int passed = 0;
  int total  = 0;

  pipe_memory_access #(.TIMEOUT_CYCLES(4), .TIMER_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .stepPipe(stepPipe), .pipeStall(pipeStall),
    .isLoad(isLoad), .isStore(isStore), .funct3(funct3), .address(address),
    .storeData(storeData), .memoryRequest(memoryRequest),
    .memoryWriteEnable(memoryWriteEnable), .memoryAddress(memoryAddress),
    .memoryByteSelect(memoryByteSelect), .memoryDataWrite(memoryDataWrite),
    .memoryAck(memoryAck), .memoryDataIn(memoryDataIn),
    .memoryDataRead(memoryDataRead), .memoryStall(memoryStall),
    .addressMisaligned(addressMisaligned), .busError(busError)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld, st, bub;
    logic [2:0]  f3;
    logic [31:0] addr, sdata;
    int          ack_at;
    logic [31:0] rdin;
    logic        exp_req, exp_mis, exp_berr, exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata;
    int          exp_stall;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic ld, st, bub, input logic [2:0] f3,
                              input logic [31:0] addr, sdata, input int ack_at,
                              input logic [31:0] rdin, input logic exp_req, exp_mis,
                              exp_berr, exp_we, input logic [3:0] exp_be,
                              input logic [31:0] exp_addr, exp_wdata,
                              input int exp_stall, input logic [31:0] exp_rdata);
    vec_t v;
    v.ld = ld; v.st = st; v.bub = bub; v.f3 = f3; v.addr = addr; v.sdata = sdata;
    v.ack_at = ack_at; v.rdin = rdin; v.exp_req = exp_req; v.exp_mis = exp_mis;
    v.exp_berr = exp_berr; v.exp_we = exp_we; v.exp_be = exp_be;
    v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_stall = exp_stall;
    v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    stepPipe = 1'b1; pipeStall = v.bub; isLoad = v.ld; isStore = v.st;
    funct3 = v.f3; address = v.addr; storeData = v.sdata; memoryAck = 1'b0;
    @(negedge clk);
    stepPipe = 1'b0; isLoad = 1'b0; isStore = 1'b0;
    chk({tag, " req"}, {31'd0, memoryRequest}, {31'd0, v.exp_req});
    chk({tag, " mis"}, {31'd0, addressMisaligned}, {31'd0, v.exp_mis});
    if (v.exp_req) begin
      chk({tag, " be"},    {28'd0, memoryByteSelect}, {28'd0, v.exp_be});
      chk({tag, " addr"},  memoryAddress, v.exp_addr);
      chk({tag, " wdata"}, memoryDataWrite, v.exp_wdata);
      chk({tag, " we"},    {31'd0, memoryWriteEnable}, {31'd0, v.exp_we});
      n = 0;
      while (memoryStall && n < 20) begin
        n++;
        if (n == v.ack_at) begin memoryAck = 1'b1; memoryDataIn = v.rdin; end
        @(negedge clk);
        memoryAck = 1'b0;
      end
      chk({tag, " stall_cycles"}, n, v.exp_stall);
      chk({tag, " berr"}, {31'd0, busError}, {31'd0, v.exp_berr});
    end else begin
      chk({tag, " stall"}, {31'd0, memoryStall}, 32'd0);
      @(negedge clk);
      chk({tag, " mis_end"}, {31'd0, addressMisaligned}, 32'd0);
      chk({tag, " req_end"}, {31'd0, memoryRequest}, 32'd0);
    end
    chk({tag, " rdata"}, memoryDataRead, v.exp_rdata);
    @(negedge clk);
    chk({tag, " berr_end"}, {31'd0, busError}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    //              ld st bub f3    addr          sdata        ack rdin          req mis ber we be       exp_addr      exp_wdata     stl rdata
    vecs[0]  = mk(1, 0, 0, 3'b010, 32'h0000_1000, 32'h0,       3, 32'hDEADBEEF, 1, 0, 0, 0, 4'b1111, 32'h0000_1000, 32'h0,       3, 32'hDEADBEEF);
    vecs[1]  = mk(0, 1, 0, 3'b000, 32'h0000_2003, 32'h0000_00A5, 1, 32'h12345678, 1, 0, 0, 1, 4'b1000, 32'h0000_2000, 32'hA5A5A5A5, 1, 32'hDEADBEEF);
    vecs[2]  = mk(1, 0, 0, 3'b001, 32'h0000_3003, 32'h0,       0, 32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,       0, 32'hDEADBEEF);
    vecs[3]  = mk(1, 0, 0, 3'b010, 32'h0000_3002, 32'h0,       0, 32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,       0, 32'hDEADBEEF);
    vecs[4]  = mk(1, 0, 0, 3'b011, 32'h0000_0000, 32'h0,       0, 32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,       0, 32'hDEADBEEF);
    vecs[5]  = mk(1, 0, 1, 3'b010, 32'h0000_0100, 32'h0,       0, 32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,       0, 32'hDEADBEEF);
    vecs[6]  = mk(0, 1, 0, 3'b001, 32'h0000_4002, 32'hFFFF1234, 2, 32'h0,       1, 0, 0, 1, 4'b1100, 32'h0000_4000, 32'h12341234, 2, 32'hDEADBEEF);
    vecs[7]  = mk(1, 1, 0, 3'b000, 32'h0000_5001, 32'h0000_003C, 1, 32'h9999_9999, 1, 0, 0, 1, 4'b0010, 32'h0000_5000, 32'h3C3C3C3C, 1, 32'hDEADBEEF);
    vecs[8]  = mk(1, 0, 0, 3'b010, 32'h0000_6000, 32'h0,       0, 32'h0,        1, 0, 1, 0, 4'b1111, 32'h0000_6000, 32'h0,       4, 32'hDEADBEEF);
    vecs[9]  = mk(1, 0, 0, 3'b100, 32'h0000_7001, 32'h0,       1, 32'hCAFEF00D, 1, 0, 0, 0, 4'b0010, 32'h0000_7000, 32'h0,       1, 32'hCAFEF00D);
    vecs[10] = mk(1, 0, 0, 3'b010, 32'h0000_8000, 32'h0,       4, 32'h0BADF00D, 1, 0, 0, 0, 4'b1111, 32'h0000_8000, 32'h0,       4, 32'h0BADF00D);

    #12;
    chk("rst req",   {31'd0, memoryRequest}, 32'd0);
    chk("rst stall", {31'd0, memoryStall}, 32'd0);
    chk("rst rdata", memoryDataRead, 32'd0);
    chk("rst addr",  memoryAddress, 32'd0);
    chk("rst flags", {29'd0, addressMisaligned, busError, memoryWriteEnable}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Ack while idle must be ignored.
    @(negedge clk);
    memoryAck = 1'b1; memoryDataIn = 32'hFFFF_FFFF;
    @(negedge clk);
    memoryAck = 1'b0;
    chk("idle_ack rdata", memoryDataRead, 32'h0BADF00D);
    chk("idle_ack req",   {31'd0, memoryRequest}, 32'd0);

    // Back-to-back loads; stepPipe held through ACCESS is ignored there.
    @(negedge clk);
    stepPipe = 1'b1; isLoad = 1'b1; funct3 = 3'b010; address = 32'h10;
    @(negedge clk);
    chk("b2b req1",  {31'd0, memoryRequest}, 32'd1);
    chk("b2b addr1", memoryAddress, 32'h10);
    address = 32'h14; memoryAck = 1'b1; memoryDataIn = 32'h1111_1111;
    @(negedge clk);
    memoryAck = 1'b0;
    chk("b2b gap",   {31'd0, memoryRequest}, 32'd0);
    chk("b2b rd1",   memoryDataRead, 32'h1111_1111);
    @(negedge clk);
    stepPipe = 1'b0; isLoad = 1'b0;
    chk("b2b req2",  {31'd0, memoryRequest}, 32'd1);
    chk("b2b addr2", memoryAddress, 32'h14);
    memoryAck = 1'b1; memoryDataIn = 32'h2222_2222;
    @(negedge clk);
    memoryAck = 1'b0;
    chk("b2b rd2",   memoryDataRead, 32'h2222_2222);
    chk("b2b stall", {31'd0, memoryStall}, 32'd0);

    // Reset mid-ACCESS, then a late ack.
    @(negedge clk);
    stepPipe = 1'b1; isLoad = 1'b1; funct3 = 3'b010; address = 32'h9000;
    @(negedge clk);
    stepPipe = 1'b0; isLoad = 1'b0;
    chk("mid req", {31'd0, memoryRequest}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid rst req",   {31'd0, memoryRequest}, 32'd0);
    chk("mid rst stall", {31'd0, memoryStall}, 32'd0);
    chk("mid rst rdata", memoryDataRead, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    memoryAck = 1'b1; memoryDataIn = 32'h5555_5555;
    @(negedge clk);
    memoryAck = 1'b0;
    chk("late_ack rdata", memoryDataRead, 32'd0);
    chk("late_ack req",   {31'd0, memoryRequest}, 32'd0);
    chk("late_ack berr",  {31'd0, busError}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_memory_access.md
Name: pipe_memory_access

Overview:
- Memory-access stage directly upstream of the store/writeback stage.
- Launches the data-bus transaction for load/store instructions from execute and holds the pipe stalled until the bus acknowledges.
- Presents the raw read word to the store stage, which performs byte alignment and sign extension.
- Detects misaligned accesses, and bus timeouts via a watchdog counter.

Parameters:
- TIMEOUT_CYCLES, 255, cycles in ACCESS without ack before abort; minimum 1.
- TIMER_WIDTH, 8, width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- stepPipe  in  1  pipe advance strobe; instruction fields valid this cycle
- pipeStall  in  1  current slot is a bubble; no access launched
- isLoad  in  1  decoded load
- isStore  in  1  decoded store
- funct3  in  3  access size/sign field
- address  in  32  effective address from ALU
- storeData  in  32  rs2 value, unaligned (byte/half in low bits)
- memoryRequest  out  1  bus request, held until ack
- memoryWriteEnable  out  1  1 = write, 0 = read; valid with memoryRequest
- memoryAddress  out  32  word-aligned address ({address[31:2],2'b00})
- memoryByteSelect  out  4  active byte lanes
- memoryDataWrite  out  32  lane-aligned store data
- memoryAck  in  1  one-cycle completion pulse; read data valid same cycle
- memoryDataIn  in  32  bus read data
- memoryDataRead  out  32  captured read word for store stage, held until next load completes
- memoryStall  out  1  stage busy; pipe must not step
- addressMisaligned  out  1  one-cycle fault pulse
- busError  out  1  one-cycle timeout pulse

Behaviour:
- Reset (async, immediate):
  - state IDLE.
  - All outputs 0, including memoryDataRead, watchdog and latched fields.
  - memoryRequest drops combinationally with rst, even mid-transaction.
  - An ack arriving after reset is ignored.
- Byte mask from funct3[1:0]: 00 → 0001, 01 → 0011, 10 → 1111, 11 → 0000 (invalid).
- Lane mask = mask << address[1:0]:
  - Any bit shifted beyond lane 3 is misaligned: half at offset 3; word at offsets 1–3.
  - A zero lane mask is invalid.
- Store data alignment:
  - Byte: storeData[7:0] replicated to all 4 lanes.
  - Half: storeData[15:0] replicated to both halves.
  - Word: unchanged.
- Launch condition: state IDLE, stepPipe=1, pipeStall=0, (isLoad|isStore)=1.
  - Valid access: latch address/lanes/data/write flag; next cycle state ACCESS, memoryRequest=1, memoryStall=1.
  - Misaligned: no request; addressMisaligned=1 for exactly the next cycle; state stays IDLE.
  - Invalid size: no request, no fault, no stall.
  - isLoad and isStore both set: treated as store.
- ACCESS state:
  - Outputs stable; watchdog increments every cycle.
  - memoryAck=1:
    - For reads, capture memoryDataIn into memoryDataRead on that edge.
    - Next cycle: IDLE, request and stall low, watchdog cleared.
  - Watchdog reaches TIMEOUT_CYCLES without ack: next cycle IDLE, busError=1 for one cycle, memoryDataRead unchanged.
  - Ack in the same cycle as timeout: ack wins, no busError.
  - stepPipe while in ACCESS is ignored.
- Minimum load latency: launch edge → request → ack in first ACCESS cycle gives stall high for exactly 1 cycle.
- Stores never modify memoryDataRead.
- Ack while IDLE is ignored.
- A launch may occur in the first IDLE cycle after completion (back-to-back).

Decomposition:
- Shared package: state encoding (IDLE, ACCESS); funct3 size constants (BYTE=2'b00, HALF=2'b01, WORD=2'b10); base-mask constants.
  - Same constants are used by the store stage's load extraction.
- One natural sub-module: memory_lane_align.
  - Combinational; computes lane mask, misaligned/invalid flags and aligned store data from funct3, address[1:0] and storeData.
  - Verified standalone.

Test Plan:
- Word load, address 0x1000, ack 3 cycles after request, memoryDataIn=0xDEADBEEF:
  - request with byteSelect=1111, writeEnable=0, memoryAddress=0x1000.
  - Stall high 3 cycles; memoryDataRead=0xDEADBEEF after.
- Byte store, address 0x2003, storeData=0x000000A5:
  - byteSelect=1000, memoryDataWrite=0xA5A5A5A5, writeEnable=1.
  - memoryDataRead unchanged.
- Half load at 0x3003 and word load at 0x3002:
  - addressMisaligned one-cycle pulse each; memoryRequest never asserted; stall stays 0.
- Timeout with TIMEOUT_CYCLES=4, no ack:
  - busError pulses once, in the cycle after the 4th ACCESS cycle.
  - State returns to IDLE; next load proceeds normally.
- Ack coincident with timeout cycle: data captured, busError=0.
- rst asserted mid-ACCESS:
  - memoryRequest and memoryStall drop without a clock edge; memoryDataRead=0.
  - A late ack after reset release has no effect.
- Back-to-back loads at 0x10 then 0x14, ack immediately each time:
  - Two requests separated by one idle cycle; second capture overwrites first.
